// File: rtl/mci_mcu_rst_req_ctrl_if.sv
// rtl/mci_mcu_rst_req_ctrl_if.sv - MCU reset-request handshake bundle
//
// Groups the register, MCU and boot-sequencer handshake signals of
// mci_mcu_rst_req_ctrl. clk and mci_rst_b stay as plain ports on the block.
//   master : the surrounding logic (register file, MCU, boot sequencer)
//   slave  : the reset-request controller
// Signals:
//   rst_req_set        single-cycle reset-request register write pulse
//   timeout_cfg        halt-ack timeout in clk cycles, 0 disables it
//   err_clr            clears the sticky timeout_err flag
//   mcu_halt_req       request to the MCU to quiesce
//   mcu_halt_ack       MCU quiesced indication (asynchronous)
//   boot_wait_rst_req  boot sequencer waiting for a reset request
//   mcu_rst_b          MCU reset as driven by the boot sequencer
//   mcu_rst_req        single-cycle reset request to the boot sequencer
//   busy               controller not idle
//   timeout_err        sticky halt-ack timeout flag
interface mci_mcu_rst_req_ctrl_if #(
    parameter int TIMEOUT_WIDTH = 16
);
    logic                     rst_req_set;
    logic [TIMEOUT_WIDTH-1:0] timeout_cfg;
    logic                     err_clr;
    logic                     mcu_halt_req;
    logic                     mcu_halt_ack;
    logic                     boot_wait_rst_req;
    logic                     mcu_rst_b;
    logic                     mcu_rst_req;
    logic                     busy;
    logic                     timeout_err;

    modport master (
        output rst_req_set,
        output timeout_cfg,
        output err_clr,
        output mcu_halt_ack,
        output boot_wait_rst_req,
        output mcu_rst_b,
        input  mcu_halt_req,
        input  mcu_rst_req,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  rst_req_set,
        input  timeout_cfg,
        input  err_clr,
        input  mcu_halt_ack,
        input  boot_wait_rst_req,
        input  mcu_rst_b,
        output mcu_halt_req,
        output mcu_rst_req,
        output busy,
        output timeout_err
    );
endinterface

// File: rtl/mci_mcu_rst_req_ctrl.sv
// rtl/mci_mcu_rst_req_ctrl.sv - MCU halt handshake and reset-request sequencer
//
// Takes a reset-request register write, asks the MCU to halt, waits for the
// (synchronised) halt acknowledge, then issues a single-cycle reset request
// to the boot sequencer once it is ready and tracks the MCU reset through
// assertion and release before returning to idle.
// Ports:
//   clk        block clock, the only clock
//   mci_rst_b  asynchronous active-low reset
//   bus        mci_mcu_rst_req_ctrl_if.slave handshake bundle
// Optional feature macro: MCI_MCU_RST_REQ_TIMEOUT_EN
//   defined   : halt-ack timeout counter, sticky timeout_err, err_clr
//   undefined : HALT waits indefinitely, timeout_err tied to 0
module mci_mcu_rst_req_ctrl #(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         mci_rst_b,
    mci_mcu_rst_req_ctrl_if.slave        bus
);

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_HALT          = 3'd1,
        ST_REQ           = 3'd2,
        ST_WAIT_ASSERT   = 3'd3,
        ST_WAIT_DEASSERT = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic   halt_req_q, halt_req_d;
    logic   rst_req_q, rst_req_d;
    logic   busy_q, busy_d;
    logic   ack_meta_q, ack_meta_d;
    logic   halt_ack_sync_q, halt_ack_sync_d;
    logic   timeout_fire;

    // Two-flop synchroniser for the MCU's asynchronous acknowledge.
    always_comb begin
        ack_meta_d      = bus.mcu_halt_ack;
        halt_ack_sync_d = ack_meta_q;
    end

`ifdef MCI_MCU_RST_REQ_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE = TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX = '1;

    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     terr_q, terr_d;

    // An ack seen in the firing cycle takes priority over the timeout.
    always_comb begin
        timeout_fire = (state_q == ST_HALT)
                    && (bus.timeout_cfg != '0)
                    && (cnt_q == (bus.timeout_cfg - CNT_ONE))
                    && !halt_ack_sync_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_IDLE) && bus.rst_req_set) begin
            cnt_d = '0;
        end else if ((state_q == ST_HALT) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Set wins over a simultaneous clear.
    always_comb begin
        terr_d = terr_q;
        if (bus.err_clr) begin
            terr_d = 1'b0;
        end
        if (timeout_fire) begin
            terr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge mci_rst_b) begin
        if (!mci_rst_b) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    logic unused_cfg;

    assign timeout_fire    = 1'b0;
    assign unused_cfg      = ^{bus.timeout_cfg, bus.err_clr};
    assign bus.timeout_err = 1'b0;
`endif

    // Next-state logic; outputs are decoded from the next state so the
    // registered versions line up exactly with the state they describe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.rst_req_set) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (halt_ack_sync_q || timeout_fire) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.boot_wait_rst_req) begin
                    state_d = ST_WAIT_ASSERT;
                end
            end
            ST_WAIT_ASSERT: begin
                if (!bus.mcu_rst_b) begin
                    state_d = ST_WAIT_DEASSERT;
                end
            end
            ST_WAIT_DEASSERT: begin
                if (bus.mcu_rst_b) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        halt_req_d = (state_d == ST_HALT);
        busy_d     = (state_d != ST_IDLE);
        // REQ is left on the same condition, so this can only be one cycle.
        rst_req_d  = (state_q == ST_REQ) && bus.boot_wait_rst_req;
    end

    always_ff @(posedge clk or negedge mci_rst_b) begin
        if (!mci_rst_b) begin
            state_q         <= ST_IDLE;
            halt_req_q      <= 1'b0;
            rst_req_q       <= 1'b0;
            busy_q          <= 1'b0;
            ack_meta_q      <= 1'b0;
            halt_ack_sync_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            halt_req_q      <= halt_req_d;
            rst_req_q       <= rst_req_d;
            busy_q          <= busy_d;
            ack_meta_q      <= ack_meta_d;
            halt_ack_sync_q <= halt_ack_sync_d;
        end
    end

    assign bus.mcu_halt_req = halt_req_q;
    assign bus.mcu_rst_req  = rst_req_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mci_mcu_rst_req_ctrl.sv
// tb/tb_mci_mcu_rst_req_ctrl.sv - scoreboard bench for mci_mcu_rst_req_ctrl
module tb_mci_mcu_rst_req_ctrl;

    localparam int TW = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mci_mcu_rst_req_ctrl_if #(.TIMEOUT_WIDTH(TW)) bus ();

    mci_mcu_rst_req_ctrl #(.TIMEOUT_WIDTH(TW)) dut (
        .clk       (clk),
        .mci_rst_b (rst_n),
        .bus       (bus)
    );

    typedef struct {
        string name;
        int    halt_len;
        int    terr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   halt_cnt = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void expect_pulse(string name, int halt_len, int terr);
        exp_t e;
        e.name     = name;
        e.halt_len = halt_len;
        e.terr     = terr;
        sb_q.push_back(e);
    endfunction

    // Monitor: counts HALT cycles and scores every mcu_rst_req pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                halt_cnt = 0;
            end else begin
                if (bus.mcu_halt_req) halt_cnt++;
                if (bus.mcu_rst_req) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_pulse", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_halt_len"}, halt_cnt, e.halt_len);
                        check({e.name, "_terr"}, int'(bus.timeout_err), e.terr);
                    end
                    halt_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_req();
        bus.rst_req_set = 1'b1;
        tick();
        bus.rst_req_set = 1'b0;
    endtask

    task automatic wait_pulse(string name);
        for (int i = 0; i < 100 && !bus.mcu_rst_req; i++) tick();
        check({name, "_pulse_seen"}, int'(bus.mcu_rst_req), 1);
    endtask

    task automatic finish_boot(string name);
        bus.mcu_rst_b = 1'b0;
        tick();
        check({name, "_busy_hold"}, int'(bus.busy), 1);
        bus.mcu_rst_b = 1'b1;
        tick();
        check({name, "_busy_clear"}, int'(bus.busy), 0);
    endtask

    initial begin
        rst_n                 = 1'b0;
        bus.rst_req_set       = 1'b0;
        bus.timeout_cfg       = '0;
        bus.err_clr           = 1'b0;
        bus.mcu_halt_ack      = 1'b0;
        bus.boot_wait_rst_req = 1'b1;
        bus.mcu_rst_b         = 1'b1;
        tick(3);
        check("rst_halt_req", int'(bus.mcu_halt_req), 0);
        check("rst_rst_req", int'(bus.mcu_rst_req), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_terr", int'(bus.timeout_err), 0);
        rst_n = 1'b1;
        tick(2);

        // s1: ack three cycles after the request, sequencer already waiting.
        expect_pulse("s1", 5, 0);
        start_req();
        check("s1_halt_req", int'(bus.mcu_halt_req), 1);
        check("s1_busy", int'(bus.busy), 1);
        tick(2);
        bus.mcu_halt_ack = 1'b1;
        wait_pulse("s1");
        bus.mcu_halt_ack = 1'b0;
        finish_boot("s1");
        tick(2);

        // s4: sequencer not ready for 20 cycles while in REQ.
        bus.boot_wait_rst_req = 1'b0;
        start_req();
        bus.mcu_halt_ack = 1'b1;
        tick(3);
        check("s4_in_req_busy", int'(bus.busy), 1);
        check("s4_in_req_halt", int'(bus.mcu_halt_req), 0);
        bus.mcu_halt_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("s4_no_pulse", int'(bus.mcu_rst_req), 0);
            tick();
        end
        expect_pulse("s4", 3, 0);
        bus.boot_wait_rst_req = 1'b1;
        wait_pulse("s4");
        finish_boot("s4");
        tick(2);

        // s5: further requests while busy are dropped.
        expect_pulse("s5", 3, 0);
        start_req();
        bus.mcu_halt_ack = 1'b1;
        tick();
        bus.rst_req_set = 1'b1;
        tick();
        bus.rst_req_set = 1'b0;
        wait_pulse("s5");
        bus.mcu_halt_ack = 1'b0;
        bus.rst_req_set  = 1'b1;
        tick();
        bus.rst_req_set  = 1'b0;
        finish_boot("s5");
        tick(5);
        check("s5_no_requeue_busy", int'(bus.busy), 0);
        check("s5_no_requeue_halt", int'(bus.mcu_halt_req), 0);

`ifdef MCI_MCU_RST_REQ_TIMEOUT_EN
        // s2: no ack, timeout after 8 HALT cycles.
        bus.timeout_cfg = 16'd8;
        expect_pulse("s2", 8, 1);
        start_req();
        wait_pulse("s2");
        finish_boot("s2");
        check("s2_terr_sticky", int'(bus.timeout_err), 1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("s2_terr_cleared", int'(bus.timeout_err), 0);

        // s2b: clear held high across the firing cycle, set wins.
        bus.timeout_cfg = 16'd2;
        expect_pulse("s2b", 2, 1);
        bus.err_clr = 1'b1;
        start_req();
        wait_pulse("s2b");
        bus.err_clr = 1'b0;
        finish_boot("s2b");
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("s2b_terr_cleared", int'(bus.timeout_err), 0);

        // s3: synchronised ack lands exactly in the firing cycle.
        bus.timeout_cfg = 16'd8;
        expect_pulse("s3", 8, 0);
        start_req();
        tick(5);
        bus.mcu_halt_ack = 1'b1;
        wait_pulse("s3");
        bus.mcu_halt_ack = 1'b0;
        finish_boot("s3");
        check("s3_terr_clear", int'(bus.timeout_err), 0);
        bus.timeout_cfg = '0;
        tick(2);
`endif

        // s6: reset during HALT aborts with no pulse afterwards.
        start_req();
        tick();
        check("s6_pre_halt", int'(bus.mcu_halt_req), 1);
        rst_n = 1'b0;
        #1;
        check("s6_halt_req", int'(bus.mcu_halt_req), 0);
        check("s6_busy", int'(bus.busy), 0);
        check("s6_rst_req", int'(bus.mcu_rst_req), 0);
        check("s6_terr", int'(bus.timeout_err), 0);
        bus.mcu_halt_ack      = 1'b1;
        bus.boot_wait_rst_req = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("s6_idle_busy", int'(bus.busy), 0);
        bus.mcu_halt_ack = 1'b0;
        tick(2);

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mci_mcu_rst_req_ctrl.md
MCI_MCU_RST_REQ_CTRL -- requirements
Module: mci_mcu_rst_req_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_WIDTH, default 16, width of the halt-ack timeout counter.
REQ-002 SHALL have port clk, input, 1, block clock; the only clock.
REQ-003 SHALL have port mci_rst_b, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rst_req_set, input, 1, single-cycle pulse from the MCU reset-request register write.
REQ-005 SHALL have port timeout_cfg, input, TIMEOUT_WIDTH, halt-ack timeout in clk cycles; 0 disables the timeout.
REQ-006 SHALL have port err_clr, input, 1, pulse that clears timeout_err.
REQ-007 SHALL have port mcu_halt_req, output, 1, request to the MCU to quiesce before reset.
REQ-008 SHALL have port mcu_halt_ack, input, 1, asynchronous MCU quiesced indication.
REQ-009 SHALL have port boot_wait_rst_req, input, 1, high while the boot sequencer sits in BOOT_WAIT_MCU_RST_REQ.
REQ-010 SHALL have port mcu_rst_b, input, 1, MCU reset as driven by the boot sequencer.
REQ-011 SHALL have port mcu_rst_req, output, 1, single-cycle reset request to the boot sequencer.
REQ-012 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-013 SHALL have port timeout_err, output, 1, sticky flag set when the halt-ack wait timed out.

Function
REQ-014 SHALL synchronise mcu_halt_ack through a 2-flop synchroniser (halt_ack_sync) before use; all other inputs are synchronous to clk.
REQ-015 SHALL implement FSM states IDLE, HALT, REQ, WAIT_ASSERT, WAIT_DEASSERT.
REQ-016 SHALL move IDLE->HALT on rst_req_set; rst_req_set outside IDLE is ignored, with no queueing.
REQ-017 SHALL drive mcu_halt_req=1 registered, exactly while the state is HALT.
REQ-018 SHALL move HALT->REQ when halt_ack_sync=1 or the timeout fires (REQ-026).
REQ-019 SHALL, in REQ, pulse mcu_rst_req for exactly one cycle in the first cycle that boot_wait_rst_req=1, then move to WAIT_ASSERT; it SHALL hold in REQ while boot_wait_rst_req=0.
REQ-020 SHALL move WAIT_ASSERT->WAIT_DEASSERT when mcu_rst_b=0.
REQ-021 SHALL move WAIT_DEASSERT->IDLE when mcu_rst_b=1.
REQ-022 SHALL, for an unreachable state encoding, return to IDLE on the next cycle.
REQ-023 SHALL register mcu_rst_req and busy, with no combinational path from inputs.
REQ-024 SHALL clear timeout_err on err_clr; a set and a clear in the same cycle resolve to set.

Reset
REQ-025 SHALL, on mci_rst_b=0, asynchronously force state IDLE, timeout counter 0, mcu_halt_req=0, mcu_rst_req=0, busy=0, timeout_err=0 and the synchroniser to 0; assertion mid-sequence aborts with no mcu_rst_req pulse.

Configuration
REQ-026 SHALL, with macro MCI_MCU_RST_REQ_TIMEOUT_EN defined, clear the counter on entry to HALT, increment it (saturating) each HALT cycle, and fire the timeout when timeout_cfg!=0 and counter==timeout_cfg-1 with halt_ack_sync=0. On timeout it sets timeout_err and proceeds to REQ. If ack and timeout occur in the same cycle, the ack wins and timeout_err is not set.
REQ-027 SHALL, without MCI_MCU_RST_REQ_TIMEOUT_EN, omit the counter, wait in HALT indefinitely for halt_ack_sync, tie timeout_err to 0, and ignore timeout_cfg and err_clr.

Verification
REQ-028 SHALL cover: rst_req_set, ack 3 cycles later, boot_wait_rst_req=1 -> one mcu_rst_req pulse; busy clears one cycle after mcu_rst_b 0->1.
REQ-029 SHALL cover: TIMEOUT_EN, timeout_cfg=8, no ack -> HALT lasts 8 cycles, timeout_err=1, one mcu_rst_req pulse; err_clr -> timeout_err=0.
REQ-030 SHALL cover: TIMEOUT_EN, timeout_cfg=8, ack arriving at the firing cycle -> timeout_err stays 0.
REQ-031 SHALL cover: boot_wait_rst_req=0 for 20 cycles in REQ -> no pulse; after it rises -> exactly one pulse.
REQ-032 SHALL cover: second rst_req_set while busy=1 -> ignored, a single mcu_rst_req pulse overall.
REQ-033 SHALL cover: mci_rst_b asserted during HALT -> all outputs 0 immediately; no pulse after release.
